huff_dec_wr_ctrl: RTL
=====================

Name: huff_dec_wr_ctrl

Overview:
Write-side address/control generator for the Huffman decoder output buffer. It accepts decoded symbols over a valid/ready handshake and writes them into the output symbol RAM at consecutive addresses starting from 0. It stops after a programmed symbol count and pulses done. It is the write-end counterpart of the encoder's read-address generator, sharing the same 8-bit symbol RAM address space.

Parameters:
ADDR_W, 8, symbol RAM address width; buffer depth = 2^ADDR_W
DATA_W, 8, decoded symbol width

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-high
start  input  1  single-cycle request to begin a block; samples len
len  input  ADDR_W+1  number of symbols in block, 0..2^ADDR_W
sym_valid  input  1  decoded symbol present
sym_data  input  DATA_W  decoded symbol
sym_ready  output  1  controller can accept a symbol this cycle
mem_we  output  1  RAM write enable, registered
mem_waddr  output  ADDR_W  RAM write address, registered
mem_wdata  output  DATA_W  RAM write data, registered
busy  output  1  block in progress (RUN or DONE state)
done  output  1  one-cycle pulse, block complete
count  output  ADDR_W+1  symbols written in current/last block

Behaviour:
- Reset (async, rst=1): state=IDLE; sym_ready=0, mem_we=0, mem_waddr=0, mem_wdata=0, busy=0, done=0, count=0, latched length=0.
- States: IDLE, RUN, DONE.
- IDLE: sym_ready=0; sym_valid ignored. On start: latch len, with values >2^ADDR_W clamped to 2^ADDR_W; count<=0. Go to RUN if len!=0, else go to DONE with no writes.
- RUN: sym_ready=1 combinationally from state only, never from sym_valid. Accept = sym_valid&&sym_ready.
- On accept in cycle N, in cycle N+1: mem_we=1, mem_waddr=count[ADDR_W-1:0] (pre-increment value), mem_wdata=sym_data. count increments at the same edge.
- Without accept in cycle N: mem_we=0 in cycle N+1. mem_waddr and mem_wdata hold their last values.
- Accepting back-to-back symbols writes one symbol per cycle with no bubbles.
- On the accept where count==latched_len-1: state goes to DONE at the same edge that issues the final write.
- DONE: lasts exactly 1 cycle; done=1, busy=1, sym_ready=0, then go to IDLE. done is therefore coincident with the last mem_we. For len=0, done asserts 1 cycle after start.
- busy=1 in RUN and DONE.
- start while not in IDLE is ignored, with len not re-sampled. start in the DONE cycle is also ignored.
- count holds its final value in IDLE until the next accepted start.
- Address range: at len=2^ADDR_W the last write is to 2^ADDR_W-1, and count reaches 2^ADDR_W without wrapping. mem_waddr never wraps within a block.
- Reset mid-block: async clear to IDLE. Any write registered for the next cycle is dropped (mem_we=0), and no done is issued.

Test Plan:
- Reset, then start with len=3. Drive sym_valid=1 continuously with symbols 0xA1,0xA2,0xA3 -> mem_we high 3 consecutive cycles; waddr 0,1,2; wdata A1,A2,A3; done pulses with the waddr=2 write; count=3; busy low the cycle after done.
- len=4 with sym_valid toggling 1,0,0,1,1,0,1 -> writes only for accepted symbols, in order, to addr 0..3. mem_waddr/mem_wdata hold during gaps. done after the 4th write.
- start with len=0 -> no mem_we; done=1 exactly one cycle after start; count=0.
- len=256, continuous valid with sym_data=addr -> 256 writes to addr 0x00..0xFF; done with the 0xFF write; count=256.
- Second start pulse mid-block (len=5 running, start with len=2 after 2 symbols) -> ignored; block completes 5 writes. Also check sym_valid=1 while IDLE -> sym_ready=0 and no write.
- Assert rst after 2 of 5 symbols, in the same cycle as an accept -> all outputs 0 immediately; no write follows; no done. A new start with len=1 then writes addr 0.

Source files
------------

// File: rtl/huff_dec_wr_ctrl_if.sv
// Decoded-symbol stream between the Huffman decoder core and the output-buffer write controller.
interface huff_dec_wr_ctrl_if #(
    parameter int DATA_W = 8
);
    logic              sym_valid;
    logic [DATA_W-1:0] sym_data;
    logic              sym_ready;

    modport master (
        output sym_valid,
        output sym_data,
        input  sym_ready
    );

    modport slave (
        input  sym_valid,
        input  sym_data,
        output sym_ready
    );
endinterface

// File: rtl/huff_dec_wr_ctrl.sv
// Output-buffer write controller: writes a block of decoded symbols to consecutive RAM
// addresses from 0, then pulses done in the same cycle as the final write.
module huff_dec_wr_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [ADDR_W:0]   len_i,
    huff_dec_wr_ctrl_if.slave sym,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_waddr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [ADDR_W:0]   count_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [ADDR_W:0] ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(1) << ADDR_W;

    state_t              state_q, state_d;
    logic [ADDR_W:0]     len_q, len_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                ready;
    logic                accept;

    // Lengths beyond the buffer depth are limited to a full buffer.
    function automatic logic [ADDR_W:0] clamp_len(input logic [ADDR_W:0] l);
        if (l > FULL) begin
            return FULL;
        end
        return l;
    endfunction

    // Ready depends only on state so the upstream valid never loops back into ready.
    assign ready  = (state_q == S_RUN);
    assign accept = sym.sym_valid && ready;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        count_d = count_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    len_d   = clamp_len(len_i);
                    count_d = '0;
                    state_d = (len_i == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (accept) begin
                    we_d    = 1'b1;
                    waddr_d = count_q[ADDR_W-1:0];
                    wdata_d = sym.sym_data;
                    count_d = count_q + ONE;
                    if (count_q == (len_q - ONE)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            count_q <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            count_q <= count_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign sym.sym_ready = ready;
    assign mem_we_o      = we_q;
    assign mem_waddr_o   = waddr_q;
    assign mem_wdata_o   = wdata_q;
    assign busy_o        = (state_q != S_IDLE);
    assign done_o        = (state_q == S_DONE);
    assign count_o       = count_q;

endmodule
